// File: rtl/mesh_egress_channel.sv
// Transmit end of a mesh output link: two virtual-channel FIFOs, selected by a
// free-running polarity bit, drained to the link consumer under ri flow control.
module mesh_egress_channel #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [PKT_W-1:0] push_packet,
  output logic [1:0]       push_ready,
  output logic [PKT_W-1:0] out_packet,
  output logic             so,
  input  logic             ri,
  output logic             polarity,
  output logic [15:0]      tx_count,
  output logic             overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic                   r_pol;
  logic [15:0]            r_tx_count;
  logic                   r_ovf;
  logic                   w_sel;
  logic                   w_vc;
  logic                   w_so;
  logic [1:0]             w_push_v;
  logic [1:0]             w_pop_v;
  logic [1:0][CW-1:0]     w_cnt;
  logic [1:0][PKT_W-1:0]  w_head;

  assign w_sel = ~r_pol;
  assign w_vc  = push_packet[PKT_W-1];
  assign w_so  = (w_cnt[w_sel] != '0);

  always_comb begin
    w_push_v = '0;
    w_pop_v  = '0;
    if (push_valid && push_ready[w_vc]) w_push_v[w_vc] = 1'b1;
    if (w_so && ri)                     w_pop_v[w_sel] = 1'b1;
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push_v[v]) r_wp <= r_wp + 1'b1;
        if (w_pop_v[v])  r_rp <= r_rp + 1'b1;
        case ({w_push_v[v], w_pop_v[v]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    // Storage is not reset; pointer/count reset is what discards queued packets.
    always_ff @(posedge clk) begin
      if (!reset && w_push_v[v]) r_mem[r_wp] <= push_packet;
    end

    assign w_cnt[v]      = r_cnt;
    assign w_head[v]     = r_mem[r_rp];
    assign push_ready[v] = (r_cnt < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pol      <= 1'b0;
      r_tx_count <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_pol <= ~r_pol;
      if (w_so && ri)                      r_tx_count <= r_tx_count + 1'b1;
      if (push_valid && !push_ready[w_vc]) r_ovf      <= 1'b1;
    end
  end

  assign so           = w_so;
  assign out_packet   = w_so ? w_head[w_sel] : '0;
  assign polarity     = r_pol;
  assign tx_count     = r_tx_count;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_mesh_egress_channel.sv
// Scoreboard bench for mesh_egress_channel: directed pushes queue the expected
// transfer order; a negedge monitor checks every so&&ri transfer against it.
module tb_mesh_egress_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [63:0] push_packet;
  logic [1:0]  push_ready;
  logic [63:0] out_packet;
  logic        so;
  logic        ri;
  logic        polarity;
  logic [15:0] tx_count;
  logic        overflow_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] expq [$];

  mesh_egress_channel #(.DEPTH(4), .PKT_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_packet  (push_packet),
    .push_ready   (push_ready),
    .out_packet   (out_packet),
    .so           (so),
    .ri           (ri),
    .polarity     (polarity),
    .tx_count     (tx_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] p);
    push_valid  = 1'b1;
    push_packet = p;
    tick();
    push_valid  = 1'b0;
  endtask

  // Monitor: every transfer must match the scoreboard head and come from VC ~polarity.
  always @(negedge clk) begin
    if (!reset && so && ri) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: got %h expected none", out_packet);
      end else begin
        logic [63:0] e;
        e = expq.pop_front();
        if (out_packet !== e || out_packet[63] !== ~polarity) begin
          bad++;
          $display("FAIL xfer_data: got %h (pol %0b) expected %h", out_packet, polarity, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; push_valid = 1'b0; push_packet = '0; ri = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state and polarity sequence 0,1,0,1
    chk("rst_so", so, 0);
    chk("rst_out", out_packet, 0);
    chk("rst_ready", push_ready, 2'b11);
    chk("rst_tx", tx_count, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("pol0", polarity, 0);
    tick(); chk("pol1", polarity, 1); chk("idle_so1", so, 0);
    tick(); chk("pol2", polarity, 0); chk("idle_so2", so, 0);
    tick(); chk("pol3", polarity, 1); chk("idle_so3", so, 0);
    tick(); chk("pol4", polarity, 0);

    // Single VC1 packet: hidden one cycle, then sent on the polarity=0 cycle
    ri = 1'b1;
    expq.push_back(64'h8000_0000_0000_00A1);
    push(64'h8000_0000_0000_00A1);
    chk("a1_pol", polarity, 1);
    chk("a1_so_early", so, 0);
    tick();
    chk("a1_so", so, 1);
    chk("a1_out", out_packet, 64'h8000_0000_0000_00A1);
    tick();
    chk("a1_tx", tx_count, 1);
    tick();
    chk("a1_empty", so, 0);

    // Fill VC0, overflow, then drain in order
    ri = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expq.push_back(64'(i));
      push(64'(i));
    end
    chk("full_ready", push_ready, 2'b10);
    chk("full_ovf0", overflow_err, 0);
    push(64'h5);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_ready", push_ready, 2'b10);
    ri = 1'b1;
    repeat (8) tick();
    chk("drain_tx", tx_count, 5);
    chk("drain_ready", push_ready, 2'b11);
    chk("ovf_sticky", overflow_err, 1);

    // Two packets per VC: alternate VC1,VC0,VC1,VC0
    ri = 1'b0;
    tick();
    push(64'h0000_0000_0000_00B0);
    push(64'h8000_0000_0000_00C0);
    push(64'h0000_0000_0000_00B1);
    push(64'h8000_0000_0000_00C1);
    chk("alt_pol", polarity, 0);
    chk("alt_first", out_packet, 64'h8000_0000_0000_00C0);
    expq.push_back(64'h8000_0000_0000_00C0);
    expq.push_back(64'h0000_0000_0000_00B0);
    expq.push_back(64'h8000_0000_0000_00C1);
    expq.push_back(64'h0000_0000_0000_00B1);
    ri = 1'b1;
    repeat (4) tick();
    chk("alt_tx", tx_count, 9);
    chk("alt_so", so, 0);

    // Full VC1 with pop and push on the same edge
    reset = 1'b1; ri = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst2_ovf", overflow_err, 0);
    chk("rst2_tx", tx_count, 0);
    for (int i = 0; i < 4; i++) begin
      expq.push_back(64'h8000_0000_0000_00D0 + 64'(i));
      push(64'h8000_0000_0000_00D0 + 64'(i));
    end
    chk("v1_full_ready", push_ready, 2'b01);
    chk("v1_full_pol", polarity, 0);
    ri = 1'b1;
    push(64'h8000_0000_0000_00D4);
    chk("popfull_ovf", overflow_err, 1);
    chk("popfull_ready", push_ready, 2'b11);
    chk("popfull_tx", tx_count, 1);
    repeat (7) tick();
    chk("popfull_drain_tx", tx_count, 4);
    chk("popfull_so", so, 0);

    // Mid-operation reset discards queued packets
    ri = 1'b0;
    push(64'h0000_0000_0000_00E0);
    push(64'h0000_0000_0000_00E1);
    push(64'h0000_0000_0000_00E2);
    chk("mid_so", so, 1);
    chk("mid_out", out_packet, 64'h0000_0000_0000_00E0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_so", so, 0);
    chk("mid_rst_out", out_packet, 0);
    chk("mid_rst_tx", tx_count, 0);
    chk("mid_rst_pol", polarity, 0);
    chk("mid_rst_ovf", overflow_err, 0);
    ri = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_gone_so", so, 0);
    end

    @(negedge clk);
    chk("scoreboard_empty", 64'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesh_egress_channel.md
Name: mesh_egress_channel

Overview:
- DUT-side transmitting end of the mesh output link: buffers packets leaving a router port and presents them to the link consumer on out_packet/so, with flow control by ri.
- Holds two virtual-channel FIFOs. Packet bit 63 selects the VC.
- Transmits from the VC opposite the current polarity, with polarity toggling every cycle.
- Sits between the router crossbar push port and the mesh boundary that the bench monitor observes.

Parameters:
- DEPTH, 4, entries per VC FIFO; power of 2, minimum 2.
- PKT_W, 64, packet width; the VC bit is PKT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push_valid  input  1  crossbar offers push_packet this cycle.
- push_packet  input  PKT_W  packet to enqueue; bit PKT_W-1 = VC.
- push_ready  output  2  per-VC space available; bit v = VC v.
- out_packet  output  PKT_W  head of the selected VC FIFO; all-zero when so=0.
- so  output  1  send-out valid.
- ri  input  1  consumer ready-in.
- polarity  output  1  cycle parity: 0 on the first cycle after reset, then toggles every cycle.
- tx_count  output  16  count of completed out transfers; wraps modulo 2^16.
- overflow_err  output  1  sticky flag: push attempted to a full VC.

Behaviour:
- Reset (reset=1 at an edge):
  - All FIFO pointers and counts = 0; FIFO contents discarded, including mid-transfer.
  - polarity=0, tx_count=0, overflow_err=0.
  - Consequently so=0, out_packet=0, push_ready=2'b11.
- Polarity register: polarity <= ~polarity every non-reset edge.
- Select: sel = ~polarity. The link carries VC1 when polarity=0 and VC0 when polarity=1.
- Output side is combinational from registered state only; there is no ri->so path:
  - so = (count[sel] != 0)
  - out_packet = so ? head[sel] : 0
- Transfer: occurs on an edge where so=1 and ri=1.
  - Pops head[sel]; tx_count increments (16-bit wrap, 0xFFFF->0x0000).
  - so=1 with ri=0: no pop; the packet stays at head of its VC.
  - On the next cycle polarity flips, so so/out_packet may change or drop without a transfer. This is legal and the consumer must not assume stability across cycles.
- Push side:
  - push_ready[v] = (count[v] < DEPTH); purely registered-state derived.
  - Accept on an edge where push_valid=1 and push_ready[push_packet[PKT_W-1]]=1. Write to the tail of that VC; count increments.
  - push_valid=1 to a full VC: packet dropped, no state change except overflow_err <= 1. overflow_err is cleared only by reset.
- Latency: a packet accepted at edge N is visible no earlier than the cycle after edge N. There is no fall-through.
  - It is visible at the first cycle where sel equals its VC and it is at head.
  - Minimum push-to-so latency is 1 cycle, maximum 2 cycles for an empty VC.
- Simultaneous push and pop on the same VC: both occur; count unchanged; ordering preserved.
- Full VC with a pop in the same cycle: push_ready is still 0. There is no same-cycle bypass, and a push is dropped and flagged.
- Push and pop on different VCs: independent.
- Pointers wrap modulo DEPTH. Per-VC FIFO order is strict; there is no ordering between VCs.
- count width = clog2(DEPTH)+1. Full when count == DEPTH; empty when count == 0.

Test Plan:
- Reset then idle 4 cycles:
  - Required: so=0, out_packet=0, push_ready=2'b11, tx_count=0, overflow_err=0.
  - Required: polarity sequence 0,1,0,1.
- Push 0x8000_0000_0000_00A1 (VC1) at the first edge after reset, ri=1:
  - Cycle after the edge: polarity=1, sel=0, so=0.
  - Next cycle: polarity=0, so=1, out_packet=0x8000_0000_0000_00A1.
  - Transfer at that edge; tx_count=1; VC1 empty afterwards.
- Fill VC0 with 4 packets 0x01..0x04, then push 0x05, ri=0 throughout:
  - Required: push_ready[0]=0 after the 4th push; 0x05 dropped; overflow_err=1 and stays 1.
  - With ri=1 afterwards: VC0 drains 0x01,0x02,0x03,0x04 in order, only on cycles where polarity=1.
- VC0 and VC1 each hold 2 packets, ri=1:
  - Required: outputs alternate VC1, VC0, VC1, VC0 on consecutive cycles; tx_count reaches 4 after 4 cycles.
- Full VC1, ri=1 on a polarity=0 cycle plus a VC1 push on the same edge:
  - Required: pop occurs, push dropped, overflow_err=1, count goes 4->3.
- Mid-operation reset with 3 packets queued and so=1:
  - Required: next cycle so=0, out_packet=0, tx_count=0, polarity=0, overflow_err=0.
  - Required: the previously queued packets never appear.
